// File: rtl/soc_io_pkg.sv
// soc_io_pkg: shared debounce constants and counter-width helper
package soc_io_pkg;
  localparam int DEBOUNCE_20MS_50MHZ = 1000000;
  localparam int DEBOUNCE_SIM = 4;
  function automatic int cnt_width(input int cycles);
    return (cycles > 2) ? $clog2(cycles) : 1;
  endfunction
endpackage

// File: rtl/debounce_channel.sv
// debounce_channel: one-bit synchronizer, counter debounce, edge pulses and sticky press latch
module debounce_channel
  import soc_io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_20MS_50MHZ,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  input  logic i_clr,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_latch
);
  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  logic          r_s1, r_s2, r_level, r_press, r_release, r_latch;
  logic [CW-1:0] r_cnt;
  logic          w_n, w_diff, w_done;
  assign w_n    = ACTIVE_LOW ? ~r_s2 : r_s2;
  assign w_diff = w_n != r_level;
  assign w_done = w_diff && (r_cnt == CW'(DEBOUNCE_CYCLES - 1));
  // sync pins, count consecutive disagreement, accept the new level and pulse on acceptance
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1      <= ACTIVE_LOW;
      r_s2      <= ACTIVE_LOW;
      r_cnt     <= '0;
      r_level   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_latch   <= 1'b0;
    end else begin
      r_s1      <= i_raw;
      r_s2      <= r_s1;
      r_cnt     <= (!w_diff || w_done) ? '0 : r_cnt + CW'(1);
      r_level   <= w_done ? w_n : r_level;
      r_press   <= w_done && w_n;
      r_release <= w_done && !w_n;
      r_latch   <= r_press | (r_latch & ~i_clr);
    end
  end
  assign o_level   = r_level;
  assign o_press   = r_press;
  assign o_release = r_release;
  assign o_latch   = r_latch;
endmodule

// File: rtl/button_debounce.sv
// button_debounce: per-channel debounce of board buttons for the button PIO
module button_debounce
  import soc_io_pkg::*;
#(
  parameter int NUM_INPUTS = 3,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_20MS_50MHZ,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                  clk_50_clk,
  input  logic                  reset_50_reset,
  input  logic [NUM_INPUTS-1:0] btn_raw,
  output logic [NUM_INPUTS-1:0] btn_level,
  output logic [NUM_INPUTS-1:0] btn_press,
  output logic [NUM_INPUTS-1:0] btn_release,
  output logic [NUM_INPUTS-1:0] press_latch,
  input  logic [NUM_INPUTS-1:0] press_clr
);
  for (genvar g = 0; g < NUM_INPUTS; g++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .ACTIVE_LOW     (ACTIVE_LOW)
    ) u_ch (
      .clk      (clk_50_clk),
      .rst      (reset_50_reset),
      .i_raw    (btn_raw[g]),
      .i_clr    (press_clr[g]),
      .o_level  (btn_level[g]),
      .o_press  (btn_press[g]),
      .o_release(btn_release[g]),
      .o_latch  (press_latch[g])
    );
  end
endmodule
